seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL provide parameter CLK_DIV, default 50000: clock cycles per digit slot; legal range BLANK_CYCLES+1 to 2^20.
REQ-002 The block SHALL provide parameter BLANK_CYCLES, default 16: dead-time cycles at the start of each slot; legal minimum 1.
REQ-003 The block SHALL provide port clock, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL provide port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL provide port enable, input, 1 bit: scanning runs while high.
REQ-006 The block SHALL provide ports seg0..seg5, input, 7 bits each: active-low segment patterns for digits 0..5, as produced by the 7-segment decoders.
REQ-007 The block SHALL provide port seg_out, output, 7 bits: shared active-low segment bus.
REQ-008 The block SHALL provide port dig_an, output, 6 bits: active-low digit enables, where bit n selects digit n.
REQ-009 The block SHALL provide port frame_done, output, 1 bit: one-cycle pulse at each completed frame.

Function
REQ-010 The block SHALL implement states IDLE, BLANK and SHOW, a 3-bit digit index (0..5) and a slot counter.
REQ-011 All outputs SHALL be registered; each output reflects the state and registers of the preceding edge.
REQ-012 IDLE behaviour: seg_out=7'h7F and dig_an=6'h3F.
REQ-013 IDLE exit: at an edge with enable=1, the block SHALL go to BLANK with digit=0 and counter=0, and SHALL snapshot seg0..seg5 into internal registers.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles with seg_out=7'h7F and dig_an=6'h3F.
REQ-015 SHOW SHALL last exactly CLK_DIV-BLANK_CYCLES cycles, driving dig_an with only bit[digit] low and seg_out with snapshot[digit].
REQ-016 SHOW exit for digit<5: the block SHALL go to BLANK and increment digit.
REQ-017 SHOW exit for digit=5 (frame end): the block SHALL wrap digit to 0, go to BLANK, re-snapshot seg0..seg5, and assert frame_done for exactly the one following cycle.
REQ-018 Slot and frame timing: each digit slot SHALL be exactly CLK_DIV cycles, and a frame exactly 6*CLK_DIV cycles.
REQ-019 Input sampling: seg0..seg5 SHALL be sampled only at snapshot edges, so input changes mid-frame never appear before the next frame.
REQ-020 At most one dig_an bit SHALL ever be low.
REQ-021 enable=0 at any edge SHALL force IDLE at that edge; outputs are blanked the next cycle, and frame_done is not asserted for an aborted frame.
REQ-022 Re-enable after IDLE SHALL always restart from digit 0 with a fresh snapshot.

Reset
REQ-023 When resetn=0, the block SHALL immediately force: state IDLE, digit 0, counter 0, snapshot registers all 7'h7F, seg_out=7'h7F, dig_an=6'h3F, frame_done=0.
REQ-024 Reset asserted mid-SHOW SHALL blank the display without waiting for a clock edge.
REQ-025 After resetn deasserts, the first edge with enable=1 SHALL follow REQ-013.

Configuration
REQ-026 With macro SEG_SCAN_DIM_EN defined, the block SHALL add input bright, 3 bits, sampled with the snapshot, plus a free-running 3-bit pwm counter that is reset to 0.
REQ-027 With SEG_SCAN_DIM_EN defined, during SHOW the block SHALL assert dig_an[digit] low only in cycles where pwm<=bright; in other cycles dig_an=6'h3F and seg_out=7'h7F. bright=7 SHALL give output identical to the undefined build.
REQ-028 With SEG_SCAN_DIM_EN undefined, port bright and the pwm logic SHALL not exist, and SHOW is always fully lit.

Verification (CLK_DIV=8, BLANK_CYCLES=2 unless noted)
REQ-029 Basic scan: reset, enable=1, seg0..seg5=7'h40,7'h79,7'h24,7'h30,7'h19,7'h12 -> per digit, 2 blank cycles then 6 cycles with dig_an=6'h3E/3D/3B/37/2F/1F and seg_out equal to the matching pattern; frame_done pulses once every 48 cycles.
REQ-030 Snapshot: change seg2 to 7'h00 during digit 1 -> digit 2 of the current frame still shows 7'h24, and the next frame shows 7'h00.
REQ-031 Enable abort: drop enable during digit 3 SHOW -> next cycle seg_out=7'h7F, dig_an=6'h3F, no frame_done; re-raise enable -> restart at digit 0.
REQ-032 Async reset: pulse resetn low for half a cycle mid-SHOW -> outputs blanked before the next clock edge, and all registers at reset values.
REQ-033 Exclusivity: run 10 frames with random inputs at CLK_DIV=3, BLANK_CYCLES=1 -> dig_an never has more than one zero bit, and frame_done period is always 18 cycles.
REQ-034 Dimming (SEG_SCAN_DIM_EN defined): bright=1 -> within SHOW, digit lit in exactly 2 of every 8 cycles aligned to pwm 0 and 1; bright=7 -> output identical to the undefined build.

Source files
------------

// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking and per-frame input snapshot.
// Optional dimming (bright input plus free-running pwm counter) is enabled by defining SEG_SCAN_DIM_EN.
module seg_scan #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic [6:0] seg5,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0] bright,
`endif
  output logic [6:0] seg_out,
  output logic [5:0] dig_an,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [19:0] SLOT_LAST = 20'(CLK_DIV - 1);
  localparam logic [19:0] SHOW_AT   = 20'(BLANK_CYCLES);

  state_t      state, state_nx;
  logic [2:0]  digit, digit_nx;
  logic [19:0] cnt, cnt_nx;
  logic        snap_take;
  logic        wrap;
  logic        lit;
  logic [6:0]  snap   [6];
  logic [6:0]  seg_in [6];

  assign seg_in[0] = seg0;
  assign seg_in[1] = seg1;
  assign seg_in[2] = seg2;
  assign seg_in[3] = seg3;
  assign seg_in[4] = seg4;
  assign seg_in[5] = seg5;

  // The counter runs over the whole slot; the first BLANK_CYCLES counts are dead time.
  always_comb begin
    state_nx  = state;
    digit_nx  = digit;
    cnt_nx    = cnt;
    snap_take = 1'b0;
    wrap      = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      digit_nx = 3'd0;
      cnt_nx   = 20'd0;
    end else if (state == IDLE) begin
      state_nx  = BLANK;
      digit_nx  = 3'd0;
      cnt_nx    = 20'd0;
      snap_take = 1'b1;
    end else if (cnt == SLOT_LAST) begin
      state_nx = BLANK;
      cnt_nx   = 20'd0;
      if (digit == 3'd5) begin
        digit_nx  = 3'd0;
        snap_take = 1'b1;
        wrap      = 1'b1;
      end else begin
        digit_nx = digit + 3'd1;
      end
    end else begin
      cnt_nx   = cnt + 20'd1;
      state_nx = (cnt_nx < SHOW_AT) ? BLANK : SHOW;
    end
  end

`ifdef SEG_SCAN_DIM_EN
  logic [2:0] pwm;
  logic [2:0] bright_q;
  logic [2:0] pwm_nx;

  assign pwm_nx = pwm + 3'd1;
  assign lit    = (state_nx == SHOW) && (pwm_nx <= bright_q);

  // Brightness is latched together with the segment snapshot so a frame never changes level midway.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pwm      <= 3'd0;
      bright_q <= 3'd7;
    end else begin
      pwm <= pwm_nx;
      if (snap_take) begin
        bright_q <= bright;
      end
    end
  end
`else
  assign lit = (state_nx == SHOW);
`endif

  // Outputs are registered from the next-state values so they describe the slot entered at this edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      digit      <= 3'd0;
      cnt        <= 20'd0;
      seg_out    <= 7'h7F;
      dig_an     <= 6'h3F;
      frame_done <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= 7'h7F;
      end
    end else begin
      state      <= state_nx;
      digit      <= digit_nx;
      cnt        <= cnt_nx;
      frame_done <= wrap;
      if (snap_take) begin
        for (int i = 0; i < 6; i++) begin
          snap[i] <= seg_in[i];
        end
      end
      if (lit) begin
        seg_out <= snap[digit_nx];
        dig_an  <= ~(6'b000001 << digit_nx);
      end else begin
        seg_out <= 7'h7F;
        dig_an  <= 6'h3F;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a timeline model (cycles since start -> slot/digit) checks two instances every cycle.
// Instance A uses CLK_DIV=8/BLANK_CYCLES=2 with directed and random stimulus; instance B uses CLK_DIV=3/BLANK_CYCLES=1.
module tb_seg_scan;

  logic clock;
  logic resetn, reset_b;
  logic en_a, en_b;
  logic [5:0][6:0] segs_a, segs_b;
  logic [6:0] seg_out_a, seg_out_b;
  logic [5:0] dig_an_a, dig_an_b;
  logic fd_a, fd_b;
  logic run;
  int total, bad;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0] bright;
  initial bright = 3'd7;
`endif

  seg_scan #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .clock(clock), .resetn(resetn), .enable(en_a),
    .seg0(segs_a[0]), .seg1(segs_a[1]), .seg2(segs_a[2]),
    .seg3(segs_a[3]), .seg4(segs_a[4]), .seg5(segs_a[5]),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .seg_out(seg_out_a), .dig_an(dig_an_a), .frame_done(fd_a)
  );

  seg_scan #(.CLK_DIV(3), .BLANK_CYCLES(1)) dut_b (
    .clock(clock), .resetn(reset_b), .enable(en_b),
    .seg0(segs_b[0]), .seg1(segs_b[1]), .seg2(segs_b[2]),
    .seg3(segs_b[3]), .seg4(segs_b[4]), .seg5(segs_b[5]),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .seg_out(seg_out_b), .dig_an(dig_an_b), .frame_done(fd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle t after the start edge of a scan, from slot arithmetic only.
  function automatic void modelOut(input int t, input int d, input int b, input logic [5:0][6:0] snap,
                                   output logic [6:0] s, output logic [5:0] a, output logic f);
    int pos, dg;
    pos = t % d;
    dg  = (t / d) % 6;
    s = 7'h7F;
    a = 6'h3F;
    f = (t > 0) && (t % (6 * d) == 0);
    if (pos >= b) begin
      s = snap[dg];
      a[dg] = 1'b0;
    end
  endfunction

  int t_a, t_b;
  bit act_a, act_b;
  logic [5:0][6:0] snap_a, snap_b;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) act_a = 1'b0;
    else if (!en_a) act_a = 1'b0;
    else if (!act_a) begin act_a = 1'b1; t_a = 0; snap_a = segs_a; end
    else begin t_a++; if (t_a % 48 == 0) snap_a = segs_a; end
  end

  always @(posedge clock or negedge reset_b) begin
    if (!reset_b) act_b = 1'b0;
    else if (!en_b) act_b = 1'b0;
    else if (!act_b) begin act_b = 1'b1; t_b = 0; snap_b = segs_b; end
    else begin t_b++; if (t_b % 18 == 0) snap_b = segs_b; end
  end

  int cyc;
  int last_fd_b;
  initial begin cyc = 0; last_fd_b = -1; end

  // Every-cycle comparison of both instances against the timeline model.
  always @(negedge clock) begin
    logic [6:0] es;
    logic [5:0] ea;
    logic ef;
    if (run) begin
      cyc++;
      es = 7'h7F; ea = 6'h3F; ef = 1'b0;
      if (act_a) modelOut(t_a, 8, 2, snap_a, es, ea, ef);
      checkOutput("a_seg_out", 32'(seg_out_a), 32'(es));
      checkOutput("a_dig_an", 32'(dig_an_a), 32'(ea));
      checkOutput("a_frame_done", 32'(fd_a), 32'(ef));
      es = 7'h7F; ea = 6'h3F; ef = 1'b0;
      if (act_b) modelOut(t_b, 3, 1, snap_b, es, ea, ef);
      checkOutput("b_seg_out", 32'(seg_out_b), 32'(es));
      checkOutput("b_dig_an", 32'(dig_an_b), 32'(ea));
      checkOutput("b_frame_done", 32'(fd_b), 32'(ef));
      checkOutput("b_one_digit", 32'($countones(~dig_an_b) <= 1), 32'd1);
      if (fd_b) begin
        if (last_fd_b >= 0) checkOutput("b_frame_period", 32'(cyc - last_fd_b), 32'd18);
        last_fd_b = cyc;
      end
    end
  end

  // Instance B just scans random patterns continuously.
  always @(negedge clock) begin
    if (run && $urandom_range(0, 3) == 0) segs_b[$urandom_range(0, 5)] = 7'($urandom);
  end

  task automatic applyStimulus();
    logic [5:0] dig_tab [6];
    logic [6:0] pat_tab [6];
    int off_cnt;
    dig_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    @(negedge clock);
    checkOutput("idle_seg_out", 32'(seg_out_a), 32'h7F);
    checkOutput("idle_dig_an", 32'(dig_an_a), 32'h3F);
    en_a = 1'b1;
    en_b = 1'b1;

    for (int t = 0; t < 190; t++) begin
      @(negedge clock);
      if (t == 0 || t == 1 || t == 8) begin
        checkOutput("slot_blank_seg", 32'(seg_out_a), 32'h7F);
        checkOutput("slot_blank_dig", 32'(dig_an_a), 32'h3F);
      end
      if (t < 48 && t % 8 == 2) begin
        checkOutput("scan_dig_an", 32'(dig_an_a), 32'(dig_tab[t / 8]));
        checkOutput("scan_seg_out", 32'(seg_out_a), 32'(pat_tab[t / 8]));
      end
      if (t == 7) checkOutput("slot_last_show", 32'(dig_an_a), 32'h3E);
      if (t == 47) checkOutput("fd_before_end", 32'(fd_a), 32'd0);
      if (t == 48 || t == 96) checkOutput("fd_at_end", 32'(fd_a), 32'd1);
      if (t == 49) checkOutput("fd_one_cycle", 32'(fd_a), 32'd0);
      if (t == 58) segs_a[2] = 7'h00;
      if (t == 66) checkOutput("snapshot_hold", 32'(seg_out_a), 32'h24);
      if (t == 114) checkOutput("snapshot_next", 32'(seg_out_a), 32'h00);
      if (t == 172) en_a = 1'b0;
      if (t == 173) begin
        checkOutput("abort_seg_out", 32'(seg_out_a), 32'h7F);
        checkOutput("abort_dig_an", 32'(dig_an_a), 32'h3F);
        checkOutput("abort_no_fd", 32'(fd_a), 32'd0);
      end
      if (t == 176) en_a = 1'b1;
      if (t == 179) begin
        checkOutput("restart_dig_an", 32'(dig_an_a), 32'h3E);
        checkOutput("restart_seg_out", 32'(seg_out_a), 32'h40);
      end
    end

    off_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) segs_a[$urandom_range(0, 5)] = 7'($urandom);
      if (off_cnt > 0) begin
        off_cnt--;
        if (off_cnt == 0) en_a = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        en_a = 1'b0;
        off_cnt = $urandom_range(1, 5);
      end
    end

    // Known restart, then asynchronous reset in the middle of digit 3's lit phase.
    @(negedge clock);
    en_a = 1'b0;
    @(negedge clock);
    en_a = 1'b1;
    segs_a[0] = 7'h40;
    repeat (28) @(negedge clock);
    checkOutput("pre_reset_dig_an", 32'(dig_an_a), 32'h37);
    @(posedge clock);
    #1 resetn = 1'b0;
    #2;
    checkOutput("async_reset_seg", 32'(seg_out_a), 32'h7F);
    checkOutput("async_reset_dig", 32'(dig_an_a), 32'h3F);
    checkOutput("async_reset_fd", 32'(fd_a), 32'd0);
    @(negedge clock);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("post_reset_dig_an", 32'(dig_an_a), 32'h3E);
    checkOutput("post_reset_seg", 32'(seg_out_a), 32'h40);
    repeat (60) @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad = 0;
    run = 1'b0;
    resetn = 1'b1;
    reset_b = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    segs_a[0] = 7'h40; segs_a[1] = 7'h79; segs_a[2] = 7'h24;
    segs_a[3] = 7'h30; segs_a[4] = 7'h19; segs_a[5] = 7'h12;
    for (int i = 0; i < 6; i++) segs_b[i] = 7'($urandom);
    #2;
    resetn = 1'b0;
    reset_b = 1'b0;
    #1;
    checkOutput("reset_seg_out", 32'(seg_out_a), 32'h7F);
    checkOutput("reset_dig_an", 32'(dig_an_a), 32'h3F);
    checkOutput("reset_frame_done", 32'(fd_a), 32'd0);
    checkOutput("reset_b_dig_an", 32'(dig_an_b), 32'h3F);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    reset_b = 1'b1;
    run = 1'b1;
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
